aes_core_arbiter: RTL and testbench

AES_CORE_ARBITER -- requirements
Module: aes_core_arbiter

---
 rtl/aes_core_arbiter.sv | 163 ++++++++++++++++
 tb/tb_aes_core_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_core_arbiter.sv
// Two-requester front end for a shared AES engine: round-robin grant, one job in flight,
// engine start/done handshake with a timeout, and a held response per requester.
`timescale 1ns/1ps

module aes_core_arbiter #(
  parameter int NK       = 4,
  parameter int MAX_WAIT = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,

  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic              i_req0_mode,
  input  logic [127:0]      i_req0_text,
  input  logic [32*NK-1:0]  i_req0_key,

  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic              i_req1_mode,
  input  logic [127:0]      i_req1_text,
  input  logic [32*NK-1:0]  i_req1_key,

  output logic              o_rsp0_valid,
  input  logic              i_rsp0_ready,
  output logic [127:0]      o_rsp0_data,
  output logic              o_rsp0_err,

  output logic              o_rsp1_valid,
  input  logic              i_rsp1_ready,
  output logic [127:0]      o_rsp1_data,
  output logic              o_rsp1_err,

  output logic              o_eng_start,
  output logic              o_eng_mode,
  output logic [127:0]      o_eng_text,
  output logic [32*NK-1:0]  o_eng_key,
  input  logic              i_eng_done,
  input  logic [127:0]      i_eng_result
);

  // state  | meaning
  // IDLE   | grant and accept a new job
  // ISSUE  | one-cycle engine start pulse
  // WAIT   | wait for engine done or timeout
  // RESP   | hold response until the granted requester consumes it

  localparam int KW = 32*NK;
  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_last_grant;
  logic            r_grant;
  logic            r_mode;
  logic [127:0]    r_text;
  logic [KW-1:0]   r_key;
  logic [127:0]    r_rsp_data;
  logic            r_rsp_err;
  logic [CW-1:0]   r_cnt;

  logic            w_grant;
  logic            w_accept;
  logic            w_timeout;
  logic            w_rsp_ready_g;

  // Round robin: a tie goes to the requester that was not served last.
  always_comb begin
    w_grant = i_req1_valid;
    if (i_req0_valid && i_req1_valid) begin
      w_grant = ~r_last_grant;
    end
  end

  assign w_accept      = (r_state == S_IDLE) && (w_grant ? i_req1_valid : i_req0_valid);
  assign w_timeout     = (r_cnt == CW'(MAX_WAIT - 1));
  assign w_rsp_ready_g = r_grant ? i_rsp1_ready : i_rsp0_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (i_eng_done || w_timeout) w_next = S_RESP;
      S_RESP:  if (w_rsp_ready_g) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_mode       <= 1'b0;
      r_text       <= '0;
      r_key        <= '0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_grant <= w_grant;
            r_mode  <= w_grant ? i_req1_mode : i_req0_mode;
            r_text  <= w_grant ? i_req1_text : i_req0_text;
            r_key   <= w_grant ? i_req1_key  : i_req0_key;
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          // Done beats timeout when both land in the same cycle.
          if (i_eng_done) begin
            r_rsp_data <= i_eng_result;
            r_rsp_err  <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RESP: begin
          if (w_rsp_ready_g) begin
            r_last_grant <= r_grant;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_req0_ready = (r_state == S_IDLE) && !w_grant && i_req0_valid;
    o_req1_ready = (r_state == S_IDLE) &&  w_grant && i_req1_valid;
    o_eng_start  = (r_state == S_ISSUE);
    o_eng_mode   = r_mode;
    o_eng_text   = r_text;
    o_eng_key    = r_key;
    o_rsp0_valid = (r_state == S_RESP) && !r_grant;
    o_rsp1_valid = (r_state == S_RESP) &&  r_grant;
    o_rsp0_data  = r_grant ? '0 : r_rsp_data;
    o_rsp1_data  = r_grant ? r_rsp_data : '0;
    o_rsp0_err   = r_rsp_err && !r_grant;
    o_rsp1_err   = r_rsp_err &&  r_grant;
  end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter: behavioural engine with fixed latency,
// response scoreboard, latency/fairness/timeout/backpressure/reset scenarios.
`timescale 1ns/1ps

module tb_aes_core_arbiter;

  localparam int KW = 128;
  localparam logic [127:0] K   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] INJ = 128'hdeadbeef_cafef00d_12345678_9abcdef0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           req0_valid, req0_ready, req0_mode;
  logic [127:0]   req0_text;
  logic [KW-1:0]  req0_key;
  logic           req1_valid, req1_ready, req1_mode;
  logic [127:0]   req1_text;
  logic [KW-1:0]  req1_key;
  logic           rsp0_valid, rsp0_ready, rsp0_err;
  logic [127:0]   rsp0_data;
  logic           rsp1_valid, rsp1_ready, rsp1_err;
  logic [127:0]   rsp1_data;
  logic           eng_start, eng_mode;
  logic [127:0]   eng_text;
  logic [KW-1:0]  eng_key;
  logic           eng_done = 1'b0;
  logic [127:0]   eng_result = '0;

  aes_core_arbiter #(.NK(4), .MAX_WAIT(64)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready), .i_req0_mode(req0_mode),
    .i_req0_text(req0_text), .i_req0_key(req0_key),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready), .i_req1_mode(req1_mode),
    .i_req1_text(req1_text), .i_req1_key(req1_key),
    .o_rsp0_valid(rsp0_valid), .i_rsp0_ready(rsp0_ready), .o_rsp0_data(rsp0_data), .o_rsp0_err(rsp0_err),
    .o_rsp1_valid(rsp1_valid), .i_rsp1_ready(rsp1_ready), .o_rsp1_data(rsp1_data), .o_rsp1_err(rsp1_err),
    .o_eng_start(eng_start), .o_eng_mode(eng_mode), .o_eng_text(eng_text), .o_eng_key(eng_key),
    .i_eng_done(eng_done), .i_eng_result(eng_result)
  );

  typedef struct {
    int           idx;
    logic [127:0] data;
    logic         err;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t obs_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in engine: known-answer pairs for the reference vector, a reversible mix otherwise.
  function automatic logic [127:0] eng_fn(input logic mode, input logic [127:0] text, input logic [127:0] key);
    if (key == K && !mode && text == PT) return CT;
    if (key == K &&  mode && text == CT) return PT;
    return text ^ {key[63:0], key[127:64]} ^ {128{mode}};
  endfunction

  function automatic logic [127:0] tx(input int n, input int k);
    return {96'h0123456789abcdef00112233, 16'(n), 16'(k)};
  endfunction

  int lat = 10;
  bit eng_never = 1'b0;
  int inj_tok = 0;
  int inj_seen = 0;
  bit busy = 1'b0;
  int rem = 0;
  int start_cyc = 0;

  always @(negedge clk) begin
    eng_done <= 1'b0;
    if (inj_tok != inj_seen) begin
      eng_done   <= 1'b1;
      eng_result <= INJ;
      inj_seen   <= inj_tok;
    end else if (busy) begin
      if (rem == 1) begin
        if (!eng_never) begin
          eng_done   <= 1'b1;
          eng_result <= eng_fn(eng_mode, eng_text, eng_key);
        end
        busy <= 1'b0;
      end else begin
        rem <= rem - 1;
      end
    end
    if (eng_start) begin
      start_cyc <= cyc;
      if (!busy) begin
        busy <= 1'b1;
        rem  <= lat;
      end
    end
  end

  int eng_starts = 0;
  int rsp0_seen = 0;
  int rsp_cnt = 0;
  int rsp_vld_cyc = 0;
  int viol = 0;
  bit prev_v = 1'b0;

  always @(negedge clk) begin
    if (eng_start) eng_starts <= eng_starts + 1;
    if (rsp0_valid) rsp0_seen <= rsp0_seen + 1;
    if ((rsp0_valid || rsp1_valid) && !prev_v) rsp_vld_cyc <= cyc;
    prev_v <= rsp0_valid || rsp1_valid;
    if ((req0_ready && req1_ready) || (rsp0_valid && rsp1_valid)) viol <= viol + 1;
    if (rsp0_valid && rsp0_ready) begin
      obs_q.push_back('{idx: 0, data: rsp0_data, err: rsp0_err});
      rsp_cnt <= rsp_cnt + 1;
    end else if (rsp1_valid && rsp1_ready) begin
      obs_q.push_back('{idx: 1, data: rsp1_data, err: rsp1_err});
      rsp_cnt <= rsp_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input bit v, input bit m, input logic [127:0] t);
    if (n == 0) begin
      req0_valid = v; req0_mode = m; req0_text = t; req0_key = K;
    end else begin
      req1_valid = v; req1_mode = m; req1_text = t; req1_key = K;
    end
  endtask

  // Returns the index accepted (or -1 on timeout); ends just after the accepting edge.
  task automatic wait_acc(output int idx);
    idx = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req0_ready && req0_valid) begin idx = 0; acc_cyc = cyc; break; end
      if (req1_ready && req1_valid) begin idx = 1; acc_cyc = cyc; break; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp_valid();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (rsp0_valid || rsp1_valid) break;
    end
  endtask

  task automatic drain();
    rsp_t e, o;
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #1;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        chk("rsp_idx", 128'(o.idx), 128'(e.idx));
        chk("rsp_data", o.data, e.data);
        chk("rsp_err", 128'(o.err), 128'(e.err));
      end
    end
    if (exp_q.size() != 0) begin
      chk("drain_pending", 128'(exp_q.size()), 128'd0);
      exp_q.delete();
    end
    cycles(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, a, base, s, n0, n1, r0;
    logic [127:0] d_bp;

    rst_n = 1'b0;
    set_req(0, 1'b0, 1'b0, '0);
    set_req(1, 1'b0, 1'b0, '0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req0_ready", 128'(req0_ready), 128'd0);
    chk("rst_rsp0_valid", 128'(rsp0_valid), 128'd0);
    chk("rst_rsp1_valid", 128'(rsp1_valid), 128'd0);
    chk("rst_eng_start", 128'(eng_start), 128'd0);
    chk("rst_eng_text", eng_text, 128'd0);
    chk("rst_rsp0_err", 128'(rsp0_err), 128'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycles(2);

    // single encrypt job with latency checks
    set_req(0, 1'b1, 1'b0, PT);
    wait_acc(idx);
    a = acc_cyc;
    chk("enc_grant", 128'(idx), 128'd0);
    req0_valid = 1'b0;
    exp_q.push_back('{idx: 0, data: CT, err: 1'b0});
    drain();
    chk("enc_start_lat", 128'(start_cyc - a), 128'd1);
    chk("enc_rsp_lat", 128'(rsp_vld_cyc - a), 128'd12);

    // tie from reset: strict alternation, one start per job
    do_reset();
    base = eng_starts;
    n0 = 0;
    n1 = 0;
    set_req(0, 1'b1, 1'b0, tx(0, 0));
    set_req(1, 1'b1, 1'b0, tx(1, 0));
    for (int k = 0; k < 6; k++) begin
      wait_acc(idx);
      chk("tie_grant", 128'(idx), 128'(k % 2));
      if (idx == 0) begin
        exp_q.push_back('{idx: 0, data: eng_fn(1'b0, req0_text, K), err: 1'b0});
        n0++;
        if (n0 < 3) req0_text = tx(0, n0);
        else req0_valid = 1'b0;
      end else if (idx == 1) begin
        exp_q.push_back('{idx: 1, data: eng_fn(1'b0, req1_text, K), err: 1'b0});
        n1++;
        if (n1 < 3) req1_text = tx(1, n1);
        else req1_valid = 1'b0;
      end
    end
    drain();
    chk("tie_starts", 128'(eng_starts - base), 128'd6);

    // decrypt on requester 1, requester 0 response stays quiet
    s = rsp0_seen;
    set_req(1, 1'b1, 1'b1, CT);
    wait_acc(idx);
    chk("dec_grant", 128'(idx), 128'd1);
    req1_valid = 1'b0;
    exp_q.push_back('{idx: 1, data: PT, err: 1'b0});
    drain();
    chk("dec_rsp0_quiet", 128'(rsp0_seen - s), 128'd0);

    // timeout, then a late done pulse while the response is held
    eng_never = 1'b1;
    rsp0_ready = 1'b0;
    set_req(0, 1'b1, 1'b0, PT ^ 128'd1);
    wait_acc(idx);
    chk("to_grant", 128'(idx), 128'd0);
    req0_valid = 1'b0;
    exp_q.push_back('{idx: 0, data: 128'd0, err: 1'b1});
    wait_rsp_valid();
    chk("to_valid", 128'(rsp0_valid), 128'd1);
    chk("to_lat", 128'(rsp_vld_cyc - start_cyc), 128'd65);
    @(posedge clk);
    #1 inj_tok++;
    cycles(3);
    @(negedge clk);
    chk("to_inj_data", rsp0_data, 128'd0);
    chk("to_inj_err", 128'(rsp0_err), 128'd1);
    chk("to_inj_valid", 128'(rsp0_valid), 128'd1);
    @(posedge clk);
    #1;
    eng_never = 1'b0;
    rsp0_ready = 1'b1;
    drain();

    // response backpressure with requester 1 waiting
    rsp0_ready = 1'b0;
    set_req(0, 1'b1, 1'b0, tx(7, 7));
    wait_acc(idx);
    chk("bp_grant0", 128'(idx), 128'd0);
    req0_valid = 1'b0;
    d_bp = eng_fn(1'b0, tx(7, 7), K);
    exp_q.push_back('{idx: 0, data: d_bp, err: 1'b0});
    wait_rsp_valid();
    @(posedge clk);
    #1 set_req(1, 1'b1, 1'b1, tx(8, 8));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_data", rsp0_data, d_bp);
      chk("bp_err", 128'(rsp0_err), 128'd0);
      chk("bp_req1_ready", 128'(req1_ready), 128'd0);
    end
    @(posedge clk);
    #1 rsp0_ready = 1'b1;
    wait_acc(idx);
    chk("bp_grant1", 128'(idx), 128'd1);
    req1_valid = 1'b0;
    exp_q.push_back('{idx: 1, data: eng_fn(1'b1, tx(8, 8), K), err: 1'b0});
    drain();

    // reset in the middle of WAIT
    set_req(0, 1'b1, 1'b1, tx(9, 9));
    wait_acc(idx);
    chk("mr_grant", 128'(idx), 128'd0);
    req0_valid = 1'b0;
    r0 = rsp_cnt;
    cycles(4);
    chk("mr_pre_text", eng_text, tx(9, 9));
    rst_n = 1'b0;
    #1;
    chk("mr_eng_start", 128'(eng_start), 128'd0);
    chk("mr_eng_mode", 128'(eng_mode), 128'd0);
    chk("mr_eng_text", eng_text, 128'd0);
    chk("mr_eng_key", eng_key, 128'd0);
    chk("mr_rsp0_valid", 128'(rsp0_valid), 128'd0);
    chk("mr_rsp1_valid", 128'(rsp1_valid), 128'd0);
    chk("mr_rsp0_data", rsp0_data, 128'd0);
    chk("mr_rsp0_err", 128'(rsp0_err), 128'd0);
    cycles(2);
    rst_n = 1'b1;
    cycles(20);
    chk("mr_no_rsp", 128'(rsp_cnt - r0), 128'd0);
    chk("mr_no_obs", 128'(obs_q.size()), 128'd0);
    set_req(0, 1'b1, 1'b0, tx(10, 0));
    set_req(1, 1'b1, 1'b0, tx(11, 0));
    wait_acc(idx);
    chk("mr_tie_first", 128'(idx), 128'd0);
    req0_valid = 1'b0;
    exp_q.push_back('{idx: 0, data: eng_fn(1'b0, tx(10, 0), K), err: 1'b0});
    wait_acc(idx);
    chk("mr_tie_second", 128'(idx), 128'd1);
    req1_valid = 1'b0;
    exp_q.push_back('{idx: 1, data: eng_fn(1'b0, tx(11, 0), K), err: 1'b0});
    drain();

    chk("one_hot_violations", 128'(viol), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
